parity_frame_receiver: RTL
==========================

Name: parity_frame_receiver

Overview:
- Serial frame receiver controller that sequences the parity detection datapath.
- Detects a start bit and shifts in NDATA data bits LSB-first while running a PAR/IMPAR parity accumulator.
- Checks the received parity bit and the stop bit.
- Delivers each frame through a single-entry valid/ready output buffer with error flags.
- Sits between a bit-rate strobe generator and a byte-level consumer.

Parameters:
- NDATA, 8, number of data bits per frame (2..16).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared immediately on assertion.
- bit_tick  in  1  one-cycle strobe; in_bit is sampled only on cycles where bit_tick=1.
- in_bit  in  1  serial line, idle high.
- out_ready  in  1  consumer accepts out_data when high together with out_valid.
- clr_ovr  in  1  synchronous clear of the overrun flag.
- out_data  out  NDATA  received data word.
- out_valid  out  1  out_data and error flags valid.
- out_par_err  out  1  parity mismatch for the buffered frame.
- out_frame_err  out  1  stop bit sampled low for the buffered frame.
- overrun  out  1  sticky flag: a completed frame was dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, shift register=0, bit counter=0, parity accumulator=PAR. All outputs 0: out_data, out_valid, out_par_err, out_frame_err, overrun, busy.
- Every FSM action below happens only on a clk edge with bit_tick=1. Without bit_tick, state holds. The only non-tick actions are output handshake and clr_ovr.
- IDLE:
  - in_bit=1: stay in IDLE.
  - in_bit=0 (start bit): go to DATA; bit counter=0; accumulator cleared to PAR.
- DATA:
  - Shift: shreg <= {in_bit, shreg[NDATA-1:1]}.
  - Accumulator toggles PAR<->IMPAR when in_bit=1.
  - Counter increments.
  - On the tick where counter == NDATA-1, go to PARITY.
- PARITY:
  - Compute perr = acc_impar XOR in_bit XOR PARITY_ODD, where acc_impar=1 means the accumulator is in IMPAR.
  - Store perr; go to STOP.
- STOP:
  - Compute ferr = ~in_bit.
  - Commit if out_valid=0 or out_ready=1: load out_data=shreg, out_par_err=perr, out_frame_err=ferr, out_valid=1.
  - Otherwise drop the frame and set overrun=1. Buffered data and flags are unchanged.
  - Go to IDLE in both cases.
- Timing: out_valid is registered. It goes high in the cycle after the stop-bit tick.
- Frame length: 1 start + NDATA data + 1 parity + 1 stop = NDATA+3 ticks.
- Handshake:
  - Transfer occurs when out_valid & out_ready; out_valid clears next cycle.
  - If a transfer and a commit happen in the same cycle, the commit wins: new data loads and out_valid stays 1.
  - out_data and flags stay stable while out_valid=1 and out_ready=0.
- overrun: sticky. It clears only on clr_ovr=1 or reset. If clr_ovr and an overrun event occur in the same cycle, set wins.
- Frame error: no resynchronisation. The FSM returns to IDLE and the next low tick starts a frame.
- busy = (state != IDLE), combinational from state.
- Reset mid-frame: partial frame discarded. The next frame after release is received normally.

Decomposition:
- Package parity_pkg:
  - typedef enum logic {PAR, IMPAR} parity_t.
  - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t.
  - Default-width constant NDATA_DEF=8.
- Sub-module parity_accumulator:
  - Ports: clk, reset, clr, en, in_bit, impar.
  - Contains the 1-bit PAR/IMPAR FSM, with synchronous clr and enable added.
  - Instantiated once; the controller drives clr on the start bit and en on DATA ticks.

Test Plan:
- NDATA=8, even parity, bit_tick every cycle, out_ready=1. Frame start 0, data 0xA5 LSB-first, parity 0, stop 1 -> out_valid pulses 1 cycle after the stop tick; out_data=0xA5, out_par_err=0, out_frame_err=0, overrun=0.
- Data 0x01 with parity bit 0 -> out_data=0x01, out_par_err=1. Repeat with parity bit 1 -> out_par_err=0.
- Data 0x3C, parity 0, stop bit 0 -> out_data=0x3C, out_frame_err=1, out_par_err=0. The following correct frame 0x55 is received with both flags 0.
- out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11 and overrun=1. Raise out_ready -> 0x11 transferred and out_valid=0. Pulse clr_ovr -> overrun=0.
- Assert reset low after start bit + 3 data bits -> busy=0 and out_valid=0 immediately (async). After release, a 0xC3 frame is received correctly.
- bit_tick every 4th cycle with in_bit held between ticks, 0x96 frame -> result identical to the every-cycle case. busy is high for exactly 11 ticks' span, from the start tick to the stop tick.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and defaults for the parity frame receiver slice.
package parity_pkg;

  typedef enum logic {PAR, IMPAR} parity_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam int unsigned NDATA_DEF = 8;

endpackage

// File: rtl/parity_accumulator.sv
// Two-state running parity tracker: toggles on each accepted '1' bit.
module parity_accumulator
  import parity_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic in_bit,
  output logic impar
);

  parity_t acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= PAR;
    end else if (clr) begin
      acc <= PAR;
    end else if (en && in_bit) begin
      acc <= (acc == PAR) ? IMPAR : PAR;
    end
  end

  assign impar = (acc == IMPAR);

endmodule

// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: start, NDATA data bits LSB-first, parity, stop;
// each frame is delivered through a single-entry valid/ready buffer.
module parity_frame_receiver
  import parity_pkg::*;
#(
  parameter int unsigned NDATA      = NDATA_DEF,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_tick,
  input  logic             in_bit,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [NDATA-1:0] out_data,
  output logic             out_valid,
  output logic             out_par_err,
  output logic             out_frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = $clog2(NDATA);

  rx_state_t        state, state_nx;
  logic [NDATA-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             perr;
  logic             impar;
  logic             cnt_last;
  logic             acc_clr;
  logic             acc_en;
  logic             stop_tick;
  logic             commit;
  logic             drop;

  assign cnt_last  = (cnt == CW'(NDATA - 1));
  assign acc_clr   = bit_tick && (state == IDLE) && !in_bit;
  assign acc_en    = bit_tick && (state == DATA);
  assign stop_tick = bit_tick && (state == STOP);
  assign commit    = stop_tick && (!out_valid || out_ready);
  assign drop      = stop_tick && out_valid && !out_ready;

  parity_accumulator u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .en     (acc_en),
    .in_bit (in_bit),
    .impar  (impar)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bit_tick) begin
      case (state)
        IDLE:    if (!in_bit) state_nx = DATA;
        DATA:    if (cnt_last) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
      perr  <= 1'b0;
    end else if (bit_tick) begin
      case (state)
        IDLE: if (!in_bit) cnt <= '0;
        DATA: begin
          shreg <= {in_bit, shreg[NDATA-1:1]};
          cnt   <= cnt + CW'(1);
        end
        PARITY:  perr <= impar ^ in_bit ^ PARITY_ODD;
        default: ;
      endcase
    end
  end

  // A commit in the same cycle as a consumer transfer takes priority,
  // so valid stays high with the new frame loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_par_err   <= 1'b0;
      out_frame_err <= 1'b0;
    end else if (commit) begin
      out_data      <= shreg;
      out_valid     <= 1'b1;
      out_par_err   <= perr;
      out_frame_err <= !in_bit;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule
